// File: rtl/mips_alu_pkg.sv
// Shared ALU-control definitions: operation codes, ALUOp/funct constants, FSM states, decode helper.
// Latency: n/a (types and a pure combinational decode function).
// Backpressure: n/a. Divide decode is present only when ALU_DIVIDER_EN is defined.
package mips_alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MUL    = 2'd1,
      ST_DIV    = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic       illegal;
      logic       is_mul;
      logic       is_div;
   } dec_t;

   // Unknown R-type functs fall back to the adder so the datapath still sees a sane code.
   function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct);
      dec_t d;
      d    = '0;
      d.op = OP_ADD;
      case (alu_op)
         ALUOP_ADD: d.op = OP_ADD;
         ALUOP_SUB: d.op = OP_SUB;
         ALUOP_OR:  d.op = OP_OR;
         default: begin
            case (funct)
               FN_ADD, FN_ADDU:   d.op = OP_ADD;
               FN_SUB, FN_SUBU:   d.op = OP_SUB;
               FN_AND:            d.op = OP_AND;
               FN_OR:             d.op = OP_OR;
               FN_SLT:            d.op = OP_SLT;
               FN_MULT, FN_MULTU: d.is_mul = 1'b1;
`ifdef ALU_DIVIDER_EN
               FN_DIV, FN_DIVU:   d.is_div = 1'b1;
`endif
               default:           d.illegal = 1'b1;
            endcase
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier: sign-magnitude, one partial product per step, 2*WIDTH result.
// Latency: WIDTH steps after start_i; prod_o is valid combinationally during the final step (done_o).
// Backpressure: none; the caller owns sequencing via step_i/last_i.
module mult_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               step_i,
   input  logic               last_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic               neg_q;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum;

   // Magnitudes are plain unsigned WIDTH bits, so the most-negative operand maps to 2^(WIDTH-1).
   always_comb begin
      mag_a  = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
      mag_b  = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
      sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{p_q[0]}}};
      p_d    = {sum, p_q[WIDTH-1:1]};
      prod_o = neg_q ? -p_d : p_d;
      done_o = step_i & last_i;
   end

   // Low half starts as the multiplier and is shifted out as the product fills in from the top.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         mcand_q <= '0;
         p_q     <= '0;
         neg_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q <= mag_a;
         p_q     <= {{WIDTH{1'b0}}, mag_b};
         neg_q   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end else if (step_i) begin
         p_q     <= p_d;
      end
   end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control: registered ALUOp/funct decode plus MULT/MULTU (and DIV/DIVU when ALU_DIVIDER_EN) sequencing into HI/LO.
// Latency: decode 1 cycle; multiply/divide busy WIDTH cycles then a 1-cycle FINISH with done and HI/LO updated.
// Backpressure: requests while busy are dropped and flagged by stall = valid_in & busy; FINISH accepts a new request.
module alu_control_seq
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       operation,
   output logic             op_valid,
   output logic             illegal,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         operation_q, operation_d;
   logic               op_valid_q, op_valid_d;
   logic               illegal_q, illegal_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   dec_t               dec;
   logic               accept, last;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign dec    = decode(alu_op, funct);
   assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign accept = valid_in & ~busy;
   assign last   = (cnt_q == CNT_W'(WIDTH - 1));
   assign stall  = valid_in & busy;
   assign done   = (state_q == ST_FINISH);

   assign operation = operation_q;
   assign op_valid  = op_valid_q;
   assign illegal   = illegal_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   mult_iter #(.WIDTH(WIDTH)) u_mult (
      .clock_i  (clock),
      .reset_i  (reset),
      .start_i  (accept & dec.is_mul),
      .step_i   (state_q == ST_MUL),
      .last_i   (last),
      .signed_i (~funct[0]),
      .a_i      (a),
      .b_i      (b),
      .done_o   (mul_done),
      .prod_o   (mul_prod)
   );

`ifdef ALU_DIVIDER_EN
   logic [WIDTH-1:0] dvs_q, rem_q, quo_q, a_q;
   logic             negq_q, negr_q, dz_q;
   logic [WIDTH-1:0] dmag_a, dmag_b, rem_n, quo_n, div_quo, div_rem;
   logic [WIDTH:0]   shifted, trial;
   logic             div_sgn, div_done;

   // Restoring step: shift the next dividend bit into the remainder and keep the subtraction if it did not borrow.
   always_comb begin
      div_sgn  = ~funct[0];
      dmag_a   = (div_sgn & a[WIDTH-1]) ? -a : a;
      dmag_b   = (div_sgn & b[WIDTH-1]) ? -b : b;
      shifted  = {rem_q, quo_q[WIDTH-1]};
      trial    = shifted - {1'b0, dvs_q};
      rem_n    = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_n    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      div_quo  = dz_q ? {WIDTH{1'b1}} : (negq_q ? -quo_n : quo_n);
      div_rem  = dz_q ? a_q : (negr_q ? -rem_n : rem_n);
      div_done = (state_q == ST_DIV) & last;
   end

   // Divider operands are captured at acceptance; the quotient register doubles as the dividend shifter.
   always_ff @(posedge clock) begin
      if (reset) begin
         dvs_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         a_q    <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         dz_q   <= 1'b0;
      end else if (accept & dec.is_div) begin
         dvs_q  <= dmag_b;
         rem_q  <= '0;
         quo_q  <= dmag_a;
         a_q    <= a;
         negq_q <= div_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         negr_q <= div_sgn & a[WIDTH-1];
         dz_q   <= (b == '0);
      end else if (state_q == ST_DIV) begin
         rem_q  <= rem_n;
         quo_q  <= quo_n;
      end
   end
`endif

   // Next state, iteration counter, decode outputs and HI/LO update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      operation_d = operation_q;
      op_valid_d  = 1'b0;
      illegal_d   = 1'b0;
      hi_d        = hi_q;
      lo_d        = lo_q;

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (accept & dec.is_mul) state_d = ST_MUL;
            if (accept & dec.is_div) state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = ST_FINISH;
         end
         default: state_d = ST_IDLE;
      endcase

      // Multi-cycle requests leave the last operation code in place.
      if (accept & ~dec.is_mul & ~dec.is_div) begin
         operation_d = dec.op;
         op_valid_d  = 1'b1;
         illegal_d   = dec.illegal;
      end

      if (mul_done) begin
         hi_d = mul_prod[2*WIDTH-1:WIDTH];
         lo_d = mul_prod[WIDTH-1:0];
      end
`ifdef ALU_DIVIDER_EN
      if (div_done) begin
         hi_d = div_rem;
         lo_d = div_quo;
      end
`endif
   end

   // State register; reset aborts any multi-cycle operation without a done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         operation_q <= OP_AND;
         op_valid_q  <= 1'b0;
         illegal_q   <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         operation_q <= operation_d;
         op_valid_q  <= op_valid_d;
         illegal_q   <= illegal_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: cycle-level behavioural model checked every cycle, plus directed literal checks.
// Latency: n/a.
// Backpressure: stimulus deliberately presents requests while busy.
module tb_alu_control_seq;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         valid_in = 1'b0;
   logic [1:0]   alu_op = 2'b00;
   logic [5:0]   funct = 6'h00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;

   logic [2:0]   operation;
   logic         op_valid, illegal, busy, stall, done;
   logic [W-1:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   alu_control_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clock     (clock),
      .reset     (reset),
      .valid_in  (valid_in),
      .alu_op    (alu_op),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .operation (operation),
      .op_valid  (op_valid),
      .illegal   (illegal),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Returns {kind[1:0], illegal, code[2:0]}; kind 0 = single-cycle, 1 = multiply, 2 = divide.
   function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'd0) return 6'b00_0_010;
      if (op == 2'd1) return 6'b00_0_110;
      if (op == 2'd3) return 6'b00_0_001;
      case (f)
         6'h20, 6'h21: return 6'b00_0_010;
         6'h22, 6'h23: return 6'b00_0_110;
         6'h24:        return 6'b00_0_000;
         6'h25:        return 6'b00_0_001;
         6'h2A:        return 6'b00_0_111;
         6'h18, 6'h19: return 6'b01_0_000;
`ifdef ALU_DIVIDER_EN
         6'h1A, 6'h1B: return 6'b10_0_000;
`endif
         default:      return 6'b00_1_010;
      endcase
   endfunction

   function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
      logic signed [63:0] sx, sy;
      sx = {{32{x[W-1]}}, x};
      sy = {{32{y[W-1]}}, y};
      if (sgn) return 64'(sx * sy);
      return {32'b0, x} * {32'b0, y};
   endfunction

`ifdef ALU_DIVIDER_EN
   function automatic logic [63:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
      longint sx, sy;
      if (y == '0) return {x, 32'hFFFF_FFFF};
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return {32'(sx % sy), 32'(sx / sy)};
      end
      return {x % y, x / y};
   endfunction
`endif

   logic [2:0]   m_op = '0;
   logic         m_opv = 1'b0, m_ill = 1'b0, m_done = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int           m_busy_left = 0;

   logic [5:0]   r_dec;
   logic         r_acc;
   logic [63:0]  r_prod;

   always_comb begin
      r_dec  = ref_decode(alu_op, funct);
      r_acc  = valid_in && (m_busy_left == 0);
      r_prod = ref_mul(a, b, ~funct[0]);
`ifdef ALU_DIVIDER_EN
      if (r_dec[5:4] == 2'd2) r_prod = ref_div(a, b, ~funct[0]);
`endif
   end

   always @(posedge clock) begin
      if (reset) begin
         m_op <= '0; m_opv <= 1'b0; m_ill <= 1'b0; m_done <= 1'b0;
         m_hi <= '0; m_lo <= '0; m_busy_left <= 0;
      end else begin
         m_done <= (m_busy_left == 1);
         if (m_busy_left == 1) begin
            m_hi <= p_hi;
            m_lo <= p_lo;
         end
         m_busy_left <= (m_busy_left > 0) ? m_busy_left - 1 : 0;
         m_opv <= 1'b0;
         m_ill <= 1'b0;
         if (r_acc) begin
            if (r_dec[5:4] == 2'd0) begin
               m_op  <= r_dec[2:0];
               m_opv <= 1'b1;
               m_ill <= r_dec[3];
            end else begin
               p_hi        <= r_prod[63:32];
               p_lo        <= r_prod[31:0];
               m_busy_left <= W;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      chk("operation", 64'(operation), 64'(m_op));
      chk("op_valid",  64'(op_valid),  64'(m_opv));
      chk("illegal",   64'(illegal),   64'(m_ill));
      chk("busy",      64'(busy),      64'(m_busy_left > 0));
      chk("stall",     64'(stall),     64'(valid_in && (m_busy_left > 0)));
      chk("done",      64'(done),      64'(m_done));
      chk("hi",        64'(hi),        64'(m_hi));
      chk("lo",        64'(lo),        64'(m_lo));
   end

   // ---------------- directed + random stimulus ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb);
      valid_in = 1'b1; alu_op = op; funct = f; a = aa; b = bb;
   endtask

   // Called right after the acceptance edge; cycle 1 is the first busy cycle.
   task automatic wait_done(output int cycles, output int stalls);
      cycles = -1;
      stalls = 0;
      for (int k = 1; k <= 2 * W && cycles < 0; k++) begin
         @(negedge clock);
         if (stall) stalls++;
         if (done) cycles = k;
         else cyc();
      end
   endtask

   task automatic long_op(input string name, input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int n, s;
      drive(2'b10, f, aa, bb);
      cyc();
      valid_in = 1'b0;
      wait_done(n, s);
      chk({name, "_latency"}, 64'(n), 64'(W + 1));
      chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
      chk({name, "_busy_in_finish"}, 64'(busy), 64'd0);
      cyc();
   endtask

   initial begin
      int n, s, dcount, r;
      logic [5:0] flist [7];
      flist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_operation", 64'(operation), 64'd0);
      chk("rst_op_valid", 64'(op_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hi_lo", {hi, lo}, 64'd0);
      cyc();

      // Single SUB decode, one-cycle op_valid.
      drive(2'b10, 6'h22, '0, '0);
      cyc();
      valid_in = 1'b0;
      @(negedge clock);
      chk("sub_op", 64'(operation), 64'h6);
      chk("sub_valid", 64'(op_valid), 64'd1);
      cyc();
      @(negedge clock);
      chk("sub_valid_drop", 64'(op_valid), 64'd0);

      // Back-to-back AND, OR, SLT, then an unknown funct.
      drive(2'b10, 6'h24, '0, '0); cyc();
      drive(2'b10, 6'h25, '0, '0); @(negedge clock);
      chk("b2b_and", {operation, op_valid}, {3'b000, 1'b1}); cyc();
      drive(2'b10, 6'h2A, '0, '0); @(negedge clock);
      chk("b2b_or", {operation, op_valid}, {3'b001, 1'b1}); cyc();
      drive(2'b10, 6'h3F, '0, '0); @(negedge clock);
      chk("b2b_slt", {operation, op_valid}, {3'b111, 1'b1}); cyc();
      valid_in = 1'b0; @(negedge clock);
      chk("illegal_fn", {operation, op_valid, illegal}, {3'b010, 1'b1, 1'b1}); cyc();
      @(negedge clock);
      chk("illegal_drop", 64'(illegal), 64'd0);

      // Multiplies with hand-computed products.
      long_op("multu_ff_2", 6'h19, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
      long_op("mult_m3_5", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      long_op("mult_min_m1", 6'h18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`ifdef ALU_DIVIDER_EN
      long_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
      long_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      long_op("div_by0", 6'h1A, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF);
`endif

      // Request held during a multiply: stalled every busy cycle, accepted in FINISH.
      drive(2'b10, 6'h18, 32'd7, 32'd9);
      cyc();
      drive(2'b00, 6'h00, '0, '0);
      wait_done(n, s);
      chk("stall_latency", 64'(n), 64'(W + 1));
      chk("stall_cycles", 64'(s), 64'(W));
      chk("stall_lo", 64'(lo), 64'd63);
      chk("stall_no_valid", 64'(op_valid), 64'd0);
      cyc();
      valid_in = 1'b0;
      @(negedge clock);
      chk("finish_accept", {operation, op_valid}, {3'b010, 1'b1});
      cyc();

      // Reset in the middle of a MULT.
      drive(2'b10, 6'h18, 32'd1234, 32'd5678);
      cyc();
      valid_in = 1'b0;
      repeat (9) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clock);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi_lo", {hi, lo}, 64'd0);
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         @(negedge clock);
         if (done) dcount++;
      end
      chk("abort_no_done", 64'(dcount), 64'd0);
      cyc();

      // Randomised traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         valid_in = ($urandom_range(0, 3) != 0);
         alu_op   = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
         r = $urandom_range(0, 39);
         if (r < 4)       funct = 6'h18 + 6'(r);
         else if (r < 32) funct = flist[r % 7];
         else             funct = 6'($urandom);
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = '0;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'h8000_0000;
            1: b = '0;
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         reset = ($urandom_range(0, 299) == 0);
         cyc();
      end
      valid_in = 1'b0;
      reset = 1'b0;
      repeat (40) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
